// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory access controller: access types,
// FSM states and the alignment rule.
package dm_pkg;

  localparam logic [2:0] DM_WORD  = 3'b000;
  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_HALFU = 3'b010;
  localparam logic [2:0] DM_BYTE  = 3'b011;
  localparam logic [2:0] DM_BYTEU = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } dm_state_e;

  // Unlisted encodings behave as full-word accesses.
  function automatic logic dm_is_word(input logic [2:0] t);
    case (t)
      DM_HALF, DM_HALFU, DM_BYTE, DM_BYTEU: return 1'b0;
      default:                              return 1'b1;
    endcase
  endfunction

  function automatic logic dm_misaligned(input logic [2:0] t, input logic [1:0] a);
    case (t)
      DM_HALF, DM_HALFU: return a[0];
      DM_BYTE, DM_BYTEU: return 1'b0;
      default:           return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Combinational lane logic: extracts and extends a load lane from a memory
// word, and merges sub-word store data into a word for read-modify-write.
module dm_lane
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  a,
  input  logic [2:0]  dmtype,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{a, 3'b000} +: 8];
    half_sel = word[{a[1], 4'b0000} +: 16];
    ldata    = word;
    merged   = wdata;
    case (dmtype)
      DM_HALF: begin
        ldata  = {{16{half_sel[15]}}, half_sel};
        merged = word;
        merged[{a[1], 4'b0000} +: 16] = wdata[15:0];
      end
      DM_HALFU: begin
        ldata  = {16'h0000, half_sel};
        merged = word;
        merged[{a[1], 4'b0000} +: 16] = wdata[15:0];
      end
      DM_BYTE: begin
        ldata  = {{24{byte_sel[7]}}, byte_sel};
        merged = word;
        merged[{a, 3'b000} +: 8] = wdata[7:0];
      end
      DM_BYTEU: begin
        ldata  = {24'h000000, byte_sel};
        merged = word;
        merged[{a, 3'b000} +: 8] = wdata[7:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// Load/store controller in front of a word-wide data memory; sub-word stores
// are performed as read-modify-write.
//
// state   | meaning
// IDLE    | waiting for req; latches the request and checks alignment
// RD      | memory word addressed; load result or merged store word formed
// WR      | mem_we high for one cycle, memory writes on the negedge
// DONE    | ready pulse, misalign valid
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int          AW        = 7,
  parameter logic [31:0] RST_RDATA = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [2:0]    dmtype,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          ready,
  output logic [31:0]   rdata,
  output logic          misalign,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  output logic          mem_we,
  input  logic [31:0]   mem_dout
);

  dm_state_e   state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  type_q, type_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic        mis_q, mis_d;
  logic        mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [31:0] mem_din_d, rdata_d;
  logic [31:0] lane_ldata, lane_merged;

  // Upper address bits alias onto the memory; they are intentionally dropped.
  logic addr_unused;
  assign addr_unused = ^addr[31:AW+2];

  dm_lane u_lane (
    .word   (mem_dout),
    .a      (off_q),
    .dmtype (type_q),
    .wdata  (wdata_q),
    .ldata  (lane_ldata),
    .merged (lane_merged)
  );

  assign ready    = (state_q == ST_DONE);
  assign misalign = (state_q == ST_DONE) && mis_q;
  assign busy     = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    type_d     = type_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    mis_d      = mis_q;
    mem_we_d   = mem_we;
    mem_addr_d = mem_addr;
    mem_din_d  = mem_din;
    rdata_d    = rdata;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d       = we;
          type_d     = dmtype;
          off_d      = addr[1:0];
          wdata_d    = wdata;
          mem_addr_d = addr[AW+1:2];
          mis_d      = dm_misaligned(dmtype, addr[1:0]);
          if (mis_d) begin
            state_d = ST_DONE;
          end else if (we && dm_is_word(dmtype)) begin
            mem_din_d = wdata;
            mem_we_d  = 1'b1;
            state_d   = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (we_q) begin
          mem_din_d = lane_merged;
          mem_we_d  = 1'b1;
          state_d   = ST_WR;
        end else begin
          rdata_d = lane_ldata;
          state_d = ST_DONE;
        end
      end
      ST_WR: begin
        mem_we_d = 1'b0;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        mis_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      type_q   <= DM_WORD;
      off_q    <= 2'b00;
      wdata_q  <= '0;
      mis_q    <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      rdata    <= RST_RDATA;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      type_q   <= type_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      mis_q    <= mis_d;
      mem_we   <= mem_we_d;
      mem_addr <= mem_addr_d;
      mem_din  <= mem_din_d;
      rdata    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: directed vector table, hand-built multi-cycle sequences,
// then random accesses compared against an arithmetic memory model.
module tb_dm_ctrl;
  import dm_pkg::*;

  localparam int AW = 7;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [2:0]    dmtype = 3'b000;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic          ready, misalign, busy, mem_we;
  logic [31:0]   rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;

  logic [31:0] dmem [0:NW-1];
  logic [31:0] ref_mem [0:NW-1];
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_idx = '0;
  logic [31:0]   tb_val = '0;

  int n_vec = 0;
  int n_err = 0;

  dm_ctrl #(.AW(AW), .RST_RDATA(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .dmtype(dmtype), .addr(addr),
    .wdata(wdata), .ready(ready), .rdata(rdata), .misalign(misalign),
    .busy(busy), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  assign mem_dout = dmem[mem_addr];
  always @(negedge clk) begin
    if (tb_we) dmem[tb_idx] <= tb_val;
    else if (mem_we) dmem[mem_addr] <= mem_din;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    tb_idx = idx[AW-1:0];
    tb_val = val;
    tb_we  = 1'b1;
    ref_mem[idx] = val;
    @(negedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic do_op(input logic w, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic [31:0] rd,
                       output logic mis, output int wecnt, output logic [AW-1:0] maddr);
    @(posedge clk); #1;
    req = 1'b1; we = w; dmtype = t; addr = a; wdata = d;
    lat = 0; wecnt = 0; rd = '0; mis = 1'b0; maddr = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (mem_we) wecnt++;
      if (ready) begin
        lat = c; rd = rdata; mis = misalign; maddr = mem_addr;
        break;
      end
    end
    req = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] e_rd;
    logic        e_mis;
    int          e_lat;
    int          e_we;
    logic [31:0] e_word;
  } vec_t;

  vec_t vt [18];

  initial begin
    int lat, wecnt, idx, off, size, pulses;
    logic [31:0] rd, v, mask, m_rdata;
    logic mis, sgn, e_mis, w;
    logic [2:0] t;
    logic [31:0] a, d;
    logic [AW-1:0] maddr;

    vt[0]  = '{1'b0, DM_BYTE,  32'h6,   32'h0,         32'hFFFF_FF99, 1'b0, 2, 0, 32'h8899_AABB};
    vt[1]  = '{1'b0, DM_HALFU, 32'h4,   32'h0,         32'h0000_AABB, 1'b0, 2, 0, 32'h8899_AABB};
    vt[2]  = '{1'b0, DM_HALF,  32'h6,   32'h0,         32'hFFFF_8899, 1'b0, 2, 0, 32'h8899_AABB};
    vt[3]  = '{1'b1, DM_BYTE,  32'hA,   32'h0000_00EE, 32'hFFFF_8899, 1'b0, 3, 1, 32'h11EE_3344};
    vt[4]  = '{1'b1, DM_WORD,  32'h3,   32'hDEAD_BEEF, 32'hFFFF_8899, 1'b1, 1, 0, 32'h0000_0000};
    vt[5]  = '{1'b0, DM_HALF,  32'h5,   32'h0,         32'hFFFF_8899, 1'b1, 1, 0, 32'h8899_AABB};
    vt[6]  = '{1'b0, DM_WORD,  32'h4,   32'h0,         32'h8899_AABB, 1'b0, 2, 0, 32'h8899_AABB};
    vt[7]  = '{1'b1, DM_HALF,  32'h6,   32'h1234_5678, 32'h8899_AABB, 1'b0, 3, 1, 32'h5678_AABB};
    vt[8]  = '{1'b0, DM_BYTEU, 32'h7,   32'h0,         32'h0000_0056, 1'b0, 2, 0, 32'h5678_AABB};
    vt[9]  = '{1'b1, DM_WORD,  32'h208, 32'hCAFE_F00D, 32'h0000_0056, 1'b0, 2, 1, 32'hCAFE_F00D};
    vt[10] = '{1'b0, 3'b111,   32'h8,   32'h0,         32'hCAFE_F00D, 1'b0, 2, 0, 32'hCAFE_F00D};
    vt[11] = '{1'b0, 3'b101,   32'hA,   32'h0,         32'hCAFE_F00D, 1'b1, 1, 0, 32'hCAFE_F00D};
    vt[12] = '{1'b0, DM_BYTE,  32'h209, 32'h0,         32'hFFFF_FFF0, 1'b0, 2, 0, 32'hCAFE_F00D};
    vt[13] = '{1'b1, DM_HALFU, 32'hA,   32'h0000_BEEF, 32'hFFFF_FFF0, 1'b0, 3, 1, 32'hBEEF_F00D};
    vt[14] = '{1'b0, DM_HALFU, 32'hA,   32'h0,         32'h0000_BEEF, 1'b0, 2, 0, 32'hBEEF_F00D};
    vt[15] = '{1'b1, DM_BYTEU, 32'h5,   32'h0000_0077, 32'h0000_BEEF, 1'b0, 3, 1, 32'h5678_77BB};
    vt[16] = '{1'b1, DM_HALF,  32'h3,   32'h0000_FFFF, 32'h0000_BEEF, 1'b1, 1, 0, 32'h0000_0000};
    vt[17] = '{1'b0, DM_BYTE,  32'h0,   32'h0,         32'h0000_0000, 1'b0, 2, 0, 32'h0000_0000};

    // reset state
    #12;
    check("rst_ready",    32'(ready),    32'h0);
    check("rst_misalign", 32'(misalign), 32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_mem_we",   32'(mem_we),   32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_din",  mem_din,       32'h0);
    check("rst_rdata",    rdata,         32'h0);
    @(posedge clk); #1 rst = 1'b0;

    poke(0, 32'h0000_0000);
    poke(1, 32'h8899_AABB);
    poke(2, 32'h1122_3344);

    foreach (vt[i]) begin
      do_op(vt[i].w, vt[i].t, vt[i].a, vt[i].d, lat, rd, mis, wecnt, maddr);
      idx = int'(vt[i].a[AW+1:2]);
      check($sformatf("vec%0d_lat", i),   32'(lat),   32'(vt[i].e_lat));
      check($sformatf("vec%0d_mis", i),   32'(mis),   32'(vt[i].e_mis));
      check($sformatf("vec%0d_rdata", i), rd,         vt[i].e_rd);
      check($sformatf("vec%0d_we", i),    32'(wecnt), 32'(vt[i].e_we));
      check($sformatf("vec%0d_maddr", i), 32'(maddr), 32'(idx));
      check($sformatf("vec%0d_word", i),  dmem[idx],  vt[i].e_word);
    end

    // back-to-back: SW held into an LW with req never dropped
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; dmtype = DM_WORD; addr = 32'h0; wdata = 32'h0BAD_CAFE;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (ready) begin lat = c; break; end
    end
    check("b2b_sw_lat", 32'(lat), 32'd2);
    we = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) check("b2b_idle_busy", 32'(busy), 32'h0);
      if (ready) begin lat = c; break; end
    end
    req = 1'b0;
    check("b2b_lw_lat",   32'(lat), 32'd3);
    check("b2b_lw_rdata", rdata,    32'h0BAD_CAFE);

    // req pulsed while busy must be ignored
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; dmtype = DM_BYTE; addr = 32'h1; wdata = 32'h0000_00AA;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; dmtype = DM_WORD; addr = 32'h4;
    @(posedge clk); #1;
    check("busy_pulse_ready", 32'(ready), 32'h1);
    req = 1'b0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (ready || busy) pulses++;
    end
    check("busy_pulse_ignored", 32'(pulses), 32'h0);
    check("busy_pulse_rdata",   rdata,       32'h0BAD_CAFE);
    check("busy_pulse_word",    dmem[0],     32'h0BAD_AAFE);

    // reset during RD of an SH
    poke(5, 32'h1234_5678);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; dmtype = DM_HALF; addr = 32'h14; wdata = 32'h0000_AAAA;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    req = 1'b0;
    check("rst_rd_mem_we", 32'(mem_we), 32'h0);
    check("rst_rd_busy",   32'(busy),   32'h0);
    check("rst_rd_rdata",  rdata,       32'h0);
    @(posedge clk); #1 rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (ready || mem_we) pulses++;
    end
    check("rst_rd_no_ready", 32'(pulses), 32'h0);
    check("rst_rd_word",     dmem[5],     32'h1234_5678);

    // reset during WR of an SW aborts the write
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; dmtype = DM_WORD; addr = 32'h14; wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("rst_wr_we_before", 32'(mem_we), 32'h1);
    rst = 1'b1;
    #1;
    req = 1'b0;
    check("rst_wr_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_wr_word", dmem[5], 32'h1234_5678);

    // random accesses against the model
    for (int i = 0; i < NW; i++) poke(i, $urandom);
    m_rdata = 32'h0;
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom_range(0, 1));
      t = 3'($urandom_range(0, 7));
      a = $urandom;
      d = $urandom;
      sgn = 1'b0;
      case (t)
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd2: size = 2;
        3'd3: begin size = 1; sgn = 1'b1; end
        3'd4: size = 1;
        default: size = 4;
      endcase
      idx   = int'((a >> 2) % NW);
      off   = int'(a % 4);
      e_mis = (a % size) != 0;
      mask  = 32'hFFFF_FFFF >> (32 - 8 * size);
      if (!e_mis) begin
        if (w) begin
          ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off))) | ((d & mask) << (8 * off));
        end else begin
          v = (ref_mem[idx] >> (8 * off)) & mask;
          if (sgn && v[8 * size - 1]) v = v | ~mask;
          m_rdata = v;
        end
      end
      do_op(w, t, a, d, lat, rd, mis, wecnt, maddr);
      check($sformatf("rnd%0d_lat", n),   32'(lat),   e_mis ? 32'd1 : (!w ? 32'd2 : (size == 4 ? 32'd2 : 32'd3)));
      check($sformatf("rnd%0d_mis", n),   32'(mis),   32'(e_mis));
      check($sformatf("rnd%0d_rdata", n), rd,         m_rdata);
      check($sformatf("rnd%0d_we", n),    32'(wecnt), (w && !e_mis) ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d_maddr", n), 32'(maddr), 32'(idx));
      check($sformatf("rnd%0d_word", n),  dmem[idx],  ref_mem[idx]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
